// File: rtl/jt89_noise.sv
// JT89 PSG noise channel: prescaled rate counter or tone2 edges clock a 16-bit
// LFSR whose low bit selects the sign of an attenuated amplitude.
module jt89_noise #(
  parameter logic [15:0] SEED = 16'h8000,
  parameter logic [15:0] TAPS = 16'h0009
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              ctrl_we,
  input  logic [2:0]        ctrl,
  input  logic              att_we,
  input  logic [3:0]        att,
  input  logic              tone2,
  output logic signed [9:0] noise
);

  localparam int unsigned CW = 6;

  logic [2:0]    ctrl_r;
  logic [3:0]    att_r;
  logic [15:0]   lfsr;
  logic [3:0]    pre;
  logic [CW-1:0] cnt;
  logic          ff;
  logic          tone2_d;

  logic          tick;
  logic          nf3;
  logic          shift;
  logic          fb;
  logic [CW-1:0] reload;
  logic [8:0]    mag;

  assign tick  = clk_en && (pre == 4'hF);
  assign nf3   = (ctrl_r[1:0] == 2'd3);
  assign shift = nf3 ? (clk_en && tone2 && !tone2_d)
                     : (tick && (cnt == '0) && !ff);
  assign fb    = ctrl_r[2] ? ^(lfsr & TAPS) : lfsr[0];

  // Half-period reload value: N-1 for N = 16/32/64
  always_comb begin
    reload = CW'(15);
    case (ctrl_r[1:0])
      2'd0:    reload = CW'(15);
      2'd1:    reload = CW'(31);
      default: reload = CW'(63);
    endcase
  end

  // 2 dB-step amplitude table; index 15 mutes the channel
  always_comb begin
    mag = 9'd0;
    case (att_r)
      4'd0:    mag = 9'd511;
      4'd1:    mag = 9'd406;
      4'd2:    mag = 9'd322;
      4'd3:    mag = 9'd256;
      4'd4:    mag = 9'd203;
      4'd5:    mag = 9'd161;
      4'd6:    mag = 9'd128;
      4'd7:    mag = 9'd102;
      4'd8:    mag = 9'd81;
      4'd9:    mag = 9'd64;
      4'd10:   mag = 9'd51;
      4'd11:   mag = 9'd40;
      4'd12:   mag = 9'd32;
      4'd13:   mag = 9'd26;
      4'd14:   mag = 9'd20;
      default: mag = 9'd0;
    endcase
  end

  // Prescaler and tone2 edge history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre     <= 4'd0;
      tone2_d <= 1'b0;
    end else if (clk_en) begin
      pre     <= pre + 4'd1;
      tone2_d <= tone2;
    end
  end

  // Rate counter; frozen while tone2 drives the shift
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick && !nf3) begin
      cnt <= (cnt == '0) ? reload : cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff <= 1'b0;
    end else if (ctrl_we) begin
      ff <= 1'b0;
    end else if (tick && !nf3 && (cnt == '0)) begin
      ff <= !ff;
    end
  end

  // Control write reloads the seed and overrides a coincident shift
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_r <= 3'd0;
      lfsr   <= SEED;
    end else if (ctrl_we) begin
      ctrl_r <= ctrl;
      lfsr   <= SEED;
    end else if (shift) begin
      lfsr   <= {fb, lfsr[15:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      att_r <= 4'hF;
    end else if (att_we) begin
      att_r <= att;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      noise <= 10'sd0;
    end else begin
      noise <= lfsr[0] ? $signed({1'b0, mag}) : -$signed({1'b0, mag});
    end
  end

endmodule

// File: tb/tb_jt89_noise.sv
// Self-checking bench for jt89_noise: directed scenarios plus randomized
// traffic compared every cycle against a behavioural model.
module tb_jt89_noise;

  logic              clk = 1'b0;
  logic              rst;
  logic              clk_en;
  logic              ctrl_we;
  logic [2:0]        ctrl;
  logic              att_we;
  logic [3:0]        att;
  logic              tone2;
  logic signed [9:0] noise;

  int checks = 0;
  int errors = 0;

  jt89_noise dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .ctrl_we(ctrl_we), .ctrl(ctrl),
    .att_we(att_we), .att(att), .tone2(tone2), .noise(noise)
  );

  always #5 clk = ~clk;

  localparam int SEED = 32'h8000;
  int amp [16] = '{511, 406, 322, 256, 203, 161, 128, 102, 81, 64, 51, 40, 32, 26, 20, 0};

  int m_pre, m_cnt, m_ff, m_t2d, m_ctrl, m_att, m_lfsr;
  logic signed [9:0] m_noise;

  task automatic model_reset();
    m_pre = 0; m_cnt = 0; m_ff = 0; m_t2d = 0;
    m_ctrl = 0; m_att = 15; m_lfsr = SEED; m_noise = 10'sd0;
  endtask

  function automatic bit model_shift(bit ce, bit t2);
    if ((m_ctrl & 3) == 3) return ce && t2 && (m_t2d == 0);
    return ce && (m_pre == 15) && (m_cnt == 0) && (m_ff == 0);
  endfunction

  task automatic model_step(bit ce, bit cwe, bit [2:0] c, bit awe, bit [3:0] a, bit t2);
    int mag, nf, fb;
    bit sh;
    mag = amp[m_att];
    nf  = m_ctrl & 3;
    sh  = model_shift(ce, t2);
    m_noise = (m_lfsr & 1) != 0 ? 10'(mag) : 10'(-mag);
    if (ce && m_pre == 15 && nf != 3) begin
      if (m_cnt == 0) begin
        m_cnt = (16 << nf) - 1;
        m_ff  = 1 - m_ff;
      end else begin
        m_cnt = m_cnt - 1;
      end
    end
    if (ce) begin
      m_pre = (m_pre + 1) % 16;
      m_t2d = int'(t2);
    end
    if (cwe) begin
      m_ctrl = int'(c); m_lfsr = SEED; m_ff = 0;
    end else if (sh) begin
      fb = (m_ctrl & 4) != 0 ? ($countones(m_lfsr & 9) % 2) : (m_lfsr & 1);
      m_lfsr = (fb << 15) | (m_lfsr >> 1);
    end
    if (awe) m_att = int'(a);
  endtask

  task automatic chk(string tag, logic signed [9:0] got, logic signed [9:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s noise=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, model at posedge, compare at next negedge
  task automatic cyc(bit ce, bit cwe, bit [2:0] c, bit awe, bit [3:0] a, bit t2);
    clk_en = ce; ctrl_we = cwe; ctrl = c; att_we = awe; att = a; tone2 = t2;
    @(posedge clk);
    model_step(ce, cwe, c, awe, a, t2);
    @(negedge clk);
    clk_en = 1'b0; ctrl_we = 1'b0; att_we = 1'b0;
    chk("model", noise, m_noise);
  endtask

  task automatic async_reset();
    #2 rst = 1'b1; tone2 = 1'b0;
    #1 chk("rst_async", noise, 10'sd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit ce, cwe, awe, t2;
    bit [2:0] c;
    bit [3:0] a;
    int tcnt;

    rst = 1'b1; clk_en = 1'b0; ctrl_we = 1'b0; ctrl = 3'd0;
    att_we = 1'b0; att = 4'd0; tone2 = 1'b0;
    model_reset();
    #1 chk("rst_init", noise, 10'sd0);
    @(negedge clk);
    rst = 1'b0;

    // Muted after reset
    for (int k = 1; k <= 20; k++) cyc(1, 0, 3'd0, 0, 4'd0, 0);
    chk("muted", noise, 10'sd0);

    // Periodic NF0 at full volume: bit0 rises on the 15th shift
    async_reset();
    cyc(0, 1, 3'b000, 1, 4'd0, 0);
    for (int k = 1; k <= 7700; k++) begin
      cyc(1, 0, 3'd0, 0, 4'd0, 0);
      if (k == 17)   chk("per_first", noise, -10'sd511);
      if (k == 7184) chk("per15_pre", noise, -10'sd511);
      if (k == 7185) chk("per15_post", noise, 10'sd511);
      if (k == 7696) chk("per16_pre", noise, 10'sd511);
      if (k == 7697) chk("per16_post", noise, -10'sd511);
    end

    // White mode at att=2: 15th shift yields 0x2001
    async_reset();
    cyc(0, 1, 3'b100, 1, 4'd2, 0);
    for (int k = 1; k <= 7186; k++) begin
      cyc(1, 0, 3'd0, 0, 4'd0, 0);
      if (k == 6672) chk("wht14", noise, -10'sd322);
      if (k == 7184) chk("wht15_pre", noise, -10'sd322);
      if (k == 7185) chk("wht15_post", noise, 10'sd322);
    end

    // NF3: one shift per tone2 rising edge, none while held high
    async_reset();
    cyc(0, 1, 3'b011, 1, 4'd0, 0);
    for (int e = 1; e <= 15; e++) begin
      for (int k = 0; k < 20; k++) cyc(1, 0, 3'd0, 0, 4'd0, 0);
      if (e == 15) chk("nf3_e14", noise, -10'sd511);
      for (int k = 0; k < 20; k++) cyc(1, 0, 3'd0, 0, 4'd0, 1);
    end
    chk("nf3_e15", noise, 10'sd511);
    for (int k = 0; k < 200; k++) cyc(1, 0, 3'd0, 0, 4'd0, 1);
    chk("nf3_hold", noise, 10'sd511);
    for (int k = 0; k < 20; k++) cyc(1, 0, 3'd0, 0, 4'd0, 0);
    for (int k = 0; k < 5; k++) cyc(1, 0, 3'd0, 0, 4'd0, 1);
    chk("nf3_e16", noise, -10'sd511);
    async_reset();

    // Randomized traffic, with ctrl writes aimed at scheduled shifts
    cyc(0, 1, 3'b000, 1, 4'd0, 0);
    t2 = 1'b0; tcnt = 0;
    for (int k = 0; k < 12000; k++) begin
      ce  = ($urandom_range(0, 3) != 0);
      awe = ($urandom_range(0, 63) == 0);
      a   = 4'($urandom_range(0, 15));
      cwe = ($urandom_range(0, 299) == 0);
      c   = 3'($urandom_range(0, 7));
      if (ce) begin
        tcnt++;
        if (tcnt == 20) begin
          tcnt = 0;
          if ($urandom_range(0, 7) != 0) t2 = !t2;
        end
      end
      if (model_shift(ce, t2) && m_lfsr != SEED && $urandom_range(0, 1) == 1) cwe = 1'b1;
      cyc(ce, cwe, c, awe, a, t2);
    end

    // Reset between edges after bringing the channel to full scale
    cyc(0, 1, 3'b000, 1, 4'd0, t2);
    cyc(0, 0, 3'd0, 0, 4'd0, t2);
    chk("pre_rst", noise, -10'sd511);
    async_reset();
    cyc(1, 0, 3'd0, 0, 4'd0, 0);
    chk("post_rst", noise, 10'sd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jt89_noise.md
Name: jt89_noise

Overview:
Noise channel generator of the JT89 PSG. Produces the signed 10-bit `noise` sample that the channel mixer sums with the three tone channels. Built from:
- a prescaler,
- a rate counter,
- a 16-bit LFSR (white or periodic mode),
- a 4-bit attenuator driving a 2 dB-step amplitude table.

Parameters:
SEED, 16'h8000, LFSR load value on reset and on every control write
TAPS, 16'h0009, LFSR feedback mask for white mode (XOR of masked bits)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
clk_en  input  1  chip clock enable; all counting/shifting qualified by it
ctrl_we  input  1  control register write strobe (one clk)
ctrl  input  3  [2]=FB (1 white, 0 periodic), [1:0]=NF rate select
att_we  input  1  attenuation register write strobe (one clk)
att  input  4  attenuation, 0 = loudest, 15 = off
tone2  input  1  tone channel 2 square output, used when NF=3
noise  output  10  signed sample to mixer

Behaviour:
- Reset (async, immediate):
  - ctrl_r=0, att_r=4'hF, lfsr=SEED
  - pre=0, cnt=0, ff=0, tone2_d=0
  - noise=0
- Register writes act on any clk, independent of clk_en.
  - ctrl_we: ctrl_r<=ctrl, lfsr<=SEED, ff<=0. pre and cnt are untouched.
  - att_we: att_r<=att.
- Prescaler: pre is 4-bit and increments on each clk_en. tick = clk_en & (pre==15).
- Rate counter, NF=0..2:
  - N = 16, 32, 64 for NF = 0, 1, 2.
  - On tick: if cnt==0, cnt<=N-1 and ff<=~ff; else cnt<=cnt-1.
  - shift = tick & cnt==0 & ff==0, i.e. on the ff 0->1 transition.
  - Resulting shift period is 512, 1024 or 2048 clk_en.
- NF=3:
  - Counter and ff are frozen.
  - tone2_d<=tone2 on each clk_en.
  - shift = clk_en & tone2 & ~tone2_d.
- LFSR shift (right shift):
  - lfsr <= {fb, lfsr[15:1]}
  - White mode: fb = ^(lfsr & TAPS).
  - Periodic mode: fb = lfsr[0].
  - Periodic mode has period 16 shifts.
- Amplitude table, indexed by att_r 0..15: 511,406,322,256,203,161,128,102,81,64,51,40,32,26,20,0.
- Output:
  - Registered, updated every clk (not only clk_en).
  - noise <= lfsr[0] ? +mag : -mag, in 10-bit two's complement.
  - att_r=15 gives noise=0 in both cases.
  - Latency: 1 clk after an lfsr or att_r change.
- Simultaneous events:
  - ctrl_we in the same cycle as a shift: the write wins; lfsr=SEED, no shift applied.
  - att_we in the same cycle as a shift: both take effect.
  - NF change 3->0..2: the counter resumes from its frozen value.
- Reset mid-operation returns all state to the reset values on the same edge, with no clk required.
- Output range: ±511 per channel. The sum of four channels fits the mixer's 12-bit internal sum.

Test Plan:
- Reset, clk_en=1 continuously, no writes -> noise=0 (att 15). lfsr 0x8000 at clk_en #16 (first shift), 0x4000 at #528, 0x2000 at #1040.
- Write att=0, ctrl=3'b000 (periodic, NF0) with clk_en always 1 -> noise=-511 until the 15th shift. That shift occurs at 16+14·512 = 7184 clk_en; noise=+511 one clk later. noise returns to -511 at the next shift. Period is 16 shifts = 8192 clk_en.
- Write ctrl=3'b100 (white) -> after 12 shifts lfsr=0x0008; 13th 0x8004, 14th 0x4002, 15th 0x2001 (noise=+mag). With att=2, noise=+322 at that point and -322 before it.
- ctrl=3'b011, toggle tone2 with a 40 clk_en period -> exactly one shift per tone2 rising edge. Holding tone2 high produces no further shifts, and cnt stays frozen.
- Write ctrl mid-sequence (lfsr≠SEED) in the same cycle as a scheduled shift -> lfsr=0x8000 on the next clk, ff=0, and the shift is suppressed.
- Assert rst asynchronously between clk edges while noise≠0 -> noise=0 and lfsr=0x8000 immediately. Verify the async path by checking before the next clk edge.
